// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between two requesters, the arbiter and a shared FIFO.
// The master side drives requests and the FIFO status; the slave side is the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int W = 8
);
    logic         req0_valid;
    logic [W-1:0] req0_data;
    logic         req0_ready;
    logic         req1_valid;
    logic [W-1:0] req1_data;
    logic         req1_ready;
    logic         fifo_full;
    logic         fifo_wr;
    logic [W-1:0] fifo_wdata;
    logic [1:0]   grant;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, fifo_full,
        input  req0_ready, req1_ready, fifo_wr, fifo_wdata, grant
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, fifo_full,
        output req0_ready, req1_ready, fifo_wr, fifo_wdata, grant
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Two-requester round-robin write arbiter for a shared FIFO with bounded bursts.
// Ties alternate on the last-served requester; a grant hands over directly when the other side waits.
module fifo_wr_arbiter #(
    parameter int W         = 8,
    parameter int MAX_BURST = 4
) (
    input logic              clk,
    input logic              reset_n,
    fifo_wr_arbiter_if.slave bus
);
    // Encodings double as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

    state_t       state;
    state_t       state_next;
    logic         last_served;
    logic [3:0]   burst_cnt;
    logic         ready0;
    logic         ready1;
    logic         wr;
    logic [W-1:0] wdata;
    logic         last_beat;
    logic         enter_grant;

    assign last_beat   = (burst_cnt == LAST_BEAT);
    assign enter_grant = (state_next != state) && (state_next != IDLE);

    // NOTE: every output of this block is given a default before the case so no path leaves a latch.
    always_comb begin
        state_next = state;
        ready0     = 1'b0;
        ready1     = 1'b0;
        wr         = 1'b0;
        wdata      = '0;
        case (state)
            IDLE: begin
                if (bus.req0_valid && bus.req1_valid)
                    state_next = last_served ? GNT0 : GNT1;
                else if (bus.req0_valid)
                    state_next = GNT0;
                else if (bus.req1_valid)
                    state_next = GNT1;
            end
            GNT0: begin
                ready0 = bus.req0_valid && !bus.fifo_full;
                wr     = ready0;
                wdata  = bus.req0_data;
                if (!bus.req0_valid || (ready0 && last_beat))
                    state_next = bus.req1_valid ? GNT1 : IDLE;
            end
            GNT1: begin
                ready1 = bus.req1_valid && !bus.fifo_full;
                wr     = ready1;
                wdata  = bus.req1_data;
                if (!bus.req1_valid || (ready1 && last_beat))
                    state_next = bus.req0_valid ? GNT0 : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            last_served <= 1'b1;
            burst_cnt   <= '0;
        end else begin
            state <= state_next;
            if (enter_grant) begin
                burst_cnt   <= '0;
                last_served <= (state_next == GNT1);
            end else if (wr) begin
                burst_cnt <= burst_cnt + 4'd1;
            end
        end
    end

    // Outputs decode from state, so an asynchronous reset clears them at once.
    assign bus.grant      = state;
    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.fifo_wr    = wr;
    assign bus.fifo_wdata = wdata;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle vectors with hand-computed outputs.
// Observed tuple is {grant, fifo_wr, req0_ready, req1_ready, fifo_wdata}.
module tb_fifo_wr_arbiter;
    logic clk;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    fifo_wr_arbiter_if #(.W(8)) bus ();

    fifo_wr_arbiter #(.W(8), .MAX_BURST(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] eg, input logic ewr,
                         input logic er0, input logic er1, input logic [7:0] ed);
        logic [12:0] obs;
        logic [12:0] exp;
        obs = {bus.grant, bus.fifo_wr, bus.req0_ready, bus.req1_ready, bus.fifo_wdata};
        exp = {eg, ewr, er0, er1, ed};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply inputs, check the combinational response, then advance one clock.
    task automatic step(input string tag, input logic v0, input logic [7:0] d0,
                        input logic v1, input logic [7:0] d1, input logic full,
                        input logic [1:0] eg, input logic ewr, input logic er0,
                        input logic er1, input logic [7:0] ed);
        bus.req0_valid = v0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_data  = d1;
        bus.fifo_full  = full;
        #1;
        check(tag, eg, ewr, er0, er1, ed);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n        = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'hA5;
        bus.req1_valid = 1'b1;
        bus.req1_data  = 8'h5B;
        bus.fifo_full  = 1'b0;
        @(posedge clk);
        #1;
        check("reset_quiet", 2'b00, 1'b0, 1'b0, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Both valid from reset: req0 wins the tie, 4+4 bursts, direct handover.
        step("tie_idle", 1, 8'hA5, 1, 8'h5B, 0, 2'b00, 0, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++)
            step("tie_g0", 1, 8'hA5, 1, 8'h5B, 0, 2'b01, 1, 1, 0, 8'hA5);
        for (int i = 0; i < 4; i++)
            step("tie_g1", 1, 8'hA5, 1, 8'h5B, 0, 2'b10, 1, 0, 1, 8'h5B);
        step("tie_back0", 1, 8'hA5, 1, 8'h5B, 0, 2'b01, 1, 1, 0, 8'hA5);
        step("drop_all", 0, 8'hA5, 0, 8'h5B, 0, 2'b01, 0, 0, 0, 8'hA5);

        // Single requester: burst limit forces one IDLE cycle, order preserved.
        step("solo_idle", 1, 8'h11, 0, 8'h00, 0, 2'b00, 0, 0, 0, 8'h00);
        step("solo_w11", 1, 8'h11, 0, 8'h00, 0, 2'b01, 1, 1, 0, 8'h11);
        step("solo_w12", 1, 8'h12, 0, 8'h00, 0, 2'b01, 1, 1, 0, 8'h12);
        step("solo_w13", 1, 8'h13, 0, 8'h00, 0, 2'b01, 1, 1, 0, 8'h13);
        step("solo_w14", 1, 8'h14, 0, 8'h00, 0, 2'b01, 1, 1, 0, 8'h14);
        step("solo_bubble", 1, 8'h15, 0, 8'h00, 0, 2'b00, 0, 0, 0, 8'h00);
        step("solo_w15", 1, 8'h15, 0, 8'h00, 0, 2'b01, 1, 1, 0, 8'h15);
        step("solo_w16", 1, 8'h16, 0, 8'h00, 0, 2'b01, 1, 1, 0, 8'h16);
        step("solo_drop", 0, 8'h17, 0, 8'h00, 0, 2'b01, 0, 0, 0, 8'h17);

        // FIFO full stalls GNT1 for three cycles; the burst still totals four writes.
        step("stall_idle", 0, 8'h00, 1, 8'h31, 0, 2'b00, 0, 0, 0, 8'h00);
        step("stall_w31", 0, 8'h00, 1, 8'h31, 0, 2'b10, 1, 0, 1, 8'h31);
        for (int i = 0; i < 3; i++)
            step("stall_full", 0, 8'h00, 1, 8'h32, 1, 2'b10, 0, 0, 0, 8'h32);
        step("stall_w32", 0, 8'h00, 1, 8'h32, 0, 2'b10, 1, 0, 1, 8'h32);
        step("stall_w33", 0, 8'h00, 1, 8'h33, 0, 2'b10, 1, 0, 1, 8'h33);
        step("stall_w34", 0, 8'h00, 1, 8'h34, 0, 2'b10, 1, 0, 1, 8'h34);
        step("stall_end", 0, 8'h00, 0, 8'h35, 0, 2'b00, 0, 0, 0, 8'h00);

        // req0 drops after two writes while req1 waits: handover with first req1 write.
        step("hand_idle", 1, 8'h41, 1, 8'h51, 0, 2'b00, 0, 0, 0, 8'h00);
        step("hand_w41", 1, 8'h41, 1, 8'h51, 0, 2'b01, 1, 1, 0, 8'h41);
        step("hand_w42", 1, 8'h42, 1, 8'h51, 0, 2'b01, 1, 1, 0, 8'h42);
        step("hand_drop", 0, 8'h43, 1, 8'h51, 0, 2'b01, 0, 0, 0, 8'h43);
        step("hand_w51", 0, 8'h43, 1, 8'h51, 0, 2'b10, 1, 0, 1, 8'h51);
        step("hand_w52", 0, 8'h43, 1, 8'h52, 0, 2'b10, 1, 0, 1, 8'h52);
        step("hand_back", 1, 8'h61, 0, 8'h53, 0, 2'b10, 0, 0, 0, 8'h53);
        step("burst_w61", 1, 8'h61, 0, 8'h53, 0, 2'b01, 1, 1, 0, 8'h61);

        // Reset mid-burst clears outputs without a clock edge; tie after release grants req0.
        bus.req0_data  = 8'h62;
        bus.req1_valid = 1'b1;
        #1;
        check("burst_w62", 2'b01, 1'b1, 1'b1, 1'b0, 8'h62);
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_async", 2'b00, 1'b0, 1'b0, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        check("rst_held", 2'b00, 1'b0, 1'b0, 1'b0, 8'h00);
        reset_n = 1'b1;
        step("post_idle", 1, 8'h71, 1, 8'h81, 0, 2'b00, 0, 0, 0, 8'h00);
        step("post_tie0", 1, 8'h71, 1, 8'h81, 0, 2'b01, 1, 1, 0, 8'h71);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
